image_job_sequencer: RTL
========================

# image_job_sequencer

Controls one image_processor job at a time for the SDK host. It takes a host start command, holds the processor in reset, releases it with a stable `cmd`, and waits for `all_ready` with a timeout. It also shares the single read port of the source-image BRAM between host readback and the processor's `w_addr`. It sits between the AXI/SDK register shim and image_processor.

## Interface
- `ADDR_WIDTH`, 19: BRAM address width.
- `DATA_WIDTH`, 12: pixel width.
- `RST_CYCLES`, 4: cycles `proc_rst` is held high at job start (≥1).
- `TIMEOUT`, 1_000_000: max RUN cycles before error (< 2^24).

Ports:
- `clk_p`  in  1  system clock; one clock domain. Reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `host_start`  in  1  single-cycle job request.
- `host_cmd`  in  2  job command, sampled with `host_start`: 0 = ELA, 1 = copy, 2/3 = invalid.
- `host_busy`  out  1  high from accepted start until DONE/ERR exit.
- `host_done`  out  1  one-cycle pulse when a job completes.
- `host_err`  out  1  sticky error flag; cleared by the next accepted valid start.
- `host_frames`  out  16  completed-job count; wraps 0xFFFF→0.
- `host_rd_req`  in  1  host BRAM read request.
- `host_rd_addr`  in  ADDR_WIDTH  host read address.
- `host_rd_gnt`  out  1  combinational grant, same cycle as the request.
- `host_rd_valid`  out  1  `host_rd_data` is valid this cycle.
- `host_rd_data`  out  DATA_WIDTH  equals `bram_dout`.
- `proc_rst`  out  1  reset to image_processor.
- `proc_cmd`  out  2  cmd to image_processor.
- `proc_all_ready`  in  1  processor completion flag.
- `proc_w_addr`  in  ADDR_WIDTH  processor BRAM address.
- `bram_addr`  out  ADDR_WIDTH  BRAM read address (combinational mux).
- `bram_dout`  in  DATA_WIDTH  BRAM read data; 1-cycle latency.

## Operation
States: IDLE, HOLD, RUN, DONE, ERR.

- **IDLE**
  - `proc_rst`=1; the host owns the BRAM port.
  - `host_start` with `host_cmd`≤1: latch cmd into `proc_cmd`, clear `host_err`, `host_busy`←1, go to HOLD.
  - `host_start` with `host_cmd`≥2: `host_err`←1, stay in IDLE, no busy.
- **HOLD**
  - `proc_rst`=1 for exactly `RST_CYCLES` cycles, then go to RUN.
  - The processor owns the BRAM port.
- **RUN**
  - `proc_rst`=0 and `proc_cmd` is held constant. This is required because image_processor restarts on any cmd change.
  - Timer counts from 0 each cycle.
  - `proc_all_ready`=1 goes to DONE.
  - Timer reaching `TIMEOUT`-1 with no ready goes to ERR.
  - If ready and timeout land on the same cycle, DONE wins.
- **DONE** (1 cycle): `host_done`=1, `host_frames`++, `proc_rst`←1, `host_busy`←0, go to IDLE.
- **ERR** (1 cycle): `host_err`←1, `proc_rst`←1, `host_busy`←0, go to IDLE. `host_frames` is unchanged.

BRAM port arbitration:
- `bram_addr` = `host_rd_addr` in IDLE; `proc_w_addr` in all other states.
- `host_rd_gnt` = `host_rd_req` and state==IDLE and not (`host_start` with valid cmd).
- If a valid start and a host read arrive in the same cycle, the start wins and the read is not granted.
- An ungranted request stays pending on the host side; it is not queued here.
- `host_rd_valid` = `host_rd_gnt` registered by one cycle.
- `host_start` while `host_busy` is ignored: no error, no latch.

## Timing
- Reset values:
  - state IDLE, `proc_rst`=1, `proc_cmd`=0, timer 0.
  - `host_busy`=0, `host_done`=0, `host_err`=0, `host_frames`=0, `host_rd_valid`=0.
- Start accepted at cycle N:
  - `host_busy`=1 and `proc_rst`=1 from N+1 through N+`RST_CYCLES`.
  - `proc_rst`=0 from N+`RST_CYCLES`+1.
- `proc_all_ready` first seen high at cycle M in RUN:
  - DONE at M+1 (`host_done` pulse, frames++).
  - IDLE at M+2, with `proc_rst`=1 and `host_busy`=0 from M+2.
- Timeout: ERR at the cycle after the count hits `TIMEOUT`-1; IDLE one cycle later.
- Host read granted at cycle N: `host_rd_valid`=1 at N+1, with `host_rd_data` = BRAM[addr@N].
- `rst` mid-job: everything returns to reset values on the next edge, and `proc_rst` is asserted immediately.

## Structure
- Shared package `img_pkg`:
  - state enum.
  - command codes `CMD_ELA`=0 and `CMD_COPY`=1.
  - `IMG_W`=400, `IMG_H`=300, `IMG_PIXELS`=120000 (shared with image_processor).
- Sub-module `job_timer`:
  - 24-bit counter with clear/enable and a terminal-count output.
  - Reused for the `RST_CYCLES` hold and the RUN timeout.
- Everything else is a single FSM plus the combinational mux.

## Test plan
- **Reset:** after `rst`, all outputs hold their reset values; `bram_addr` follows `host_rd_addr`.
- **Copy job:** start with cmd=1, `RST_CYCLES`=4.
  - `proc_rst` is high for 4 cycles, then `proc_cmd`=1, low `proc_rst`.
  - Ready model fires after 2000 cycles → one `host_done` pulse, `host_frames`=1, `host_busy` drops 2 cycles after ready.
- **Timeout:** `TIMEOUT`=100 and ready never rises → `host_err`=1 exactly 101 cycles after RUN entry, `host_frames`=0, back in IDLE.
  - A subsequent valid start clears `host_err`.
- **Invalid command:** start with cmd=3 → `host_err`=1, `host_busy` stays 0, `proc_rst` stays 1.
- **Arbitration:**
  - Read of addr 0x1F3 in IDLE → `host_rd_valid` next cycle with the BRAM word.
  - Read during RUN → `gnt`=0 and `bram_addr`=`proc_w_addr`.
  - Simultaneous valid start + read → no grant, job starts.
- **Wrap and ignore:** preload `host_frames`=0xFFFF, complete a job → 0x0000.
  - A second `host_start` while busy changes nothing.

Source files
------------

// File: rtl/img_pkg.sv
// Types and constants shared between the job sequencer and image_processor.
package img_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [1:0] CMD_ELA  = 2'd0;
    localparam logic [1:0] CMD_COPY = 2'd1;

    localparam int IMG_W      = 400;
    localparam int IMG_H      = 300;
    localparam int IMG_PIXELS = IMG_W * IMG_H;

    function automatic logic cmd_valid(input logic [1:0] cmd);
        return cmd <= CMD_COPY;
    endfunction

endpackage

// File: rtl/job_timer.sv
// Free-running cycle counter with clear/enable and a terminal-count flag.
module job_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + 1'b1;
    end

    assign o_tc = (r_count == i_limit);

endmodule

// File: rtl/image_job_sequencer.sv
// Runs one image_processor job at a time and shares the source-BRAM read
// port between host readback (IDLE) and the processor (all other states).
module image_job_sequencer
    import img_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 19,
    parameter int          DATA_WIDTH  = 12,
    parameter int          RST_CYCLES  = 4,
    parameter int          TIMEOUT     = 1_000_000,
    parameter logic [15:0] FRAMES_INIT = 16'h0000
) (
    input  logic                  clk_p,
    input  logic                  rst,
    input  logic                  host_start,
    input  logic [1:0]            host_cmd,
    output logic                  host_busy,
    output logic                  host_done,
    output logic                  host_err,
    output logic [15:0]           host_frames,
    input  logic                  host_rd_req,
    input  logic [ADDR_WIDTH-1:0] host_rd_addr,
    output logic                  host_rd_gnt,
    output logic                  host_rd_valid,
    output logic [DATA_WIDTH-1:0] host_rd_data,
    output logic                  proc_rst,
    output logic [1:0]            proc_cmd,
    input  logic                  proc_all_ready,
    input  logic [ADDR_WIDTH-1:0] proc_w_addr,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    localparam logic [23:0] HOLD_LAST = 24'(RST_CYCLES - 1);
    localparam logic [23:0] RUN_LAST  = 24'(TIMEOUT - 1);

    state_t      r_state;
    logic [1:0]  r_cmd;
    logic        r_err;
    logic [15:0] r_frames;
    logic        r_rd_valid;

    logic        w_idle;
    logic        w_start_ok;
    logic        w_gnt;
    logic        w_tmr_en;
    logic        w_tmr_clr;
    logic        w_tc;
    logic [23:0] w_limit;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_start_ok = host_start && cmd_valid(host_cmd);
    assign w_gnt      = host_rd_req && w_idle && !w_start_ok;

    // One timer serves both phases; it restarts from 0 on every phase change.
    assign w_tmr_en  = (r_state == ST_HOLD) || (r_state == ST_RUN);
    assign w_tmr_clr = !w_tmr_en || w_tc;
    assign w_limit   = (r_state == ST_HOLD) ? HOLD_LAST : RUN_LAST;

    job_timer #(.W(24)) u_timer (
        .clk     (clk_p),
        .rst     (rst),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .i_limit (w_limit),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk_p) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cmd      <= CMD_ELA;
            r_err      <= 1'b0;
            r_frames   <= FRAMES_INIT;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_gnt;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_cmd   <= host_cmd;
                        r_err   <= 1'b0;
                        r_state <= ST_HOLD;
                    end else if (host_start) begin
                        r_err <= 1'b1;
                    end
                end
                ST_HOLD: if (w_tc) r_state <= ST_RUN;
                ST_RUN: begin
                    // Ready on the timeout cycle still counts as a completed job.
                    if (proc_all_ready)
                        r_state <= ST_DONE;
                    else if (w_tc)
                        r_state <= ST_ERR;
                end
                ST_DONE: begin
                    r_frames <= r_frames + 16'd1;
                    r_state  <= ST_IDLE;
                end
                ST_ERR: begin
                    r_err   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // rst feeds proc_rst directly so the processor is held without waiting an edge.
    assign proc_rst      = rst || (r_state != ST_RUN);
    assign proc_cmd      = r_cmd;
    assign host_busy     = !w_idle;
    assign host_done     = (r_state == ST_DONE);
    assign host_err      = r_err;
    assign host_frames   = r_frames;
    assign host_rd_gnt   = w_gnt;
    assign host_rd_valid = r_rd_valid;
    assign host_rd_data  = bram_dout;
    assign bram_addr     = w_idle ? host_rd_addr : proc_w_addr;

endmodule
